// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, op and
// mtvec mode encodings, and bit positions inside mstatus/mie/mip.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running cycle counter; a write replaces one half while the other half
// keeps its incremented value, so the written half never carries across.
module csr_cycle_counter #(
  parameter int CYCLE_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [CYCLE_W/2-1:0] wdata,
  output logic [CYCLE_W-1:0]   count
);

  localparam int HALF = CYCLE_W / 2;

  logic [CYCLE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CYCLE_W'(1);
    if (wr_lo) count_d[HALF-1:0]       = wdata;
    if (wr_hi) count_d[CYCLE_W-1:HALF] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr access decode, trap entry / mret state updates,
// interrupt gating and trap vector generation.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CYCLE_W     = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic            csr_rd,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] pc,
  input  logic            trap,
  input  logic [XLEN-1:0] cause,
  input  logic            mret,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] rdata,
  output logic            illegal,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] trap_vec,
  output logic            irq_req
);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mpie_q, mpie_d;
  logic            mtie_q, mtie_d;
  logic            meie_q, meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [CYCLE_W-1:0] cycle_cnt;
  logic [XLEN-1:0]    csr_val, wval, tvec_base;
  logic               mapped, wr_en, wr_lo, wr_hi;
  csr_op_e            op;

  assign op = csr_op_e'(csr_op);

  // Current value of the addressed CSR, independent of csr_rd.
  always_comb begin
    csr_val = '0;
    mapped  = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_val[MSTATUS_MIE]  = mstatus_mie_q;
        csr_val[MSTATUS_MPIE] = mpie_q;
        csr_val[12:11]        = 2'b11;
      end
      CSR_MIE: begin
        csr_val[MIE_MTIE] = mtie_q;
        csr_val[MIE_MEIE] = meie_q;
      end
      CSR_MTVEC:   csr_val = mtvec_q;
      CSR_MEPC:    csr_val = mepc_q;
      CSR_MCAUSE:  csr_val = mcause_q;
      CSR_MIP: begin
        csr_val[MIE_MTIE] = irq_timer;
        csr_val[MIE_MEIE] = irq_ext;
      end
      CSR_MCYCLE:  csr_val = XLEN'(cycle_cnt[CYCLE_W/2-1:0]);
      CSR_MCYCLEH: csr_val = XLEN'(cycle_cnt[CYCLE_W-1:CYCLE_W/2]);
      default:     mapped  = 1'b0;
    endcase
  end

  assign illegal = ((csr_rd || op != CSR_OP_NONE) && !mapped) ||
                   (op != CSR_OP_NONE && csr_addr == CSR_MIP);
  assign rdata   = csr_rd ? csr_val : '0;
  assign wr_en   = (op != CSR_OP_NONE) && !illegal;
  assign wr_lo   = wr_en && csr_addr == CSR_MCYCLE;
  assign wr_hi   = wr_en && csr_addr == CSR_MCYCLEH;

  always_comb begin
    case (op)
      CSR_OP_RW: wval = wdata;
      CSR_OP_RS: wval = csr_val | wdata;
      CSR_OP_RC: wval = csr_val & ~wdata;
      default:   wval = csr_val;
    endcase
  end

  // trap beats mret beats CSR write on any state they share.
  always_comb begin
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    mtie_d        = mtie_q;
    meie_d        = meie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    if (trap) begin
      mepc_d        = pc & ~XLEN'(3);
      mcause_d      = cause;
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
    end else if (mret) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
    end
    if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: if (!trap && !mret) begin
          mstatus_mie_d = wval[MSTATUS_MIE];
          mpie_d        = wval[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          mtie_d = wval[MIE_MTIE];
          meie_d = wval[MIE_MEIE];
        end
        CSR_MTVEC: mtvec_d = {wval[XLEN-1:2],
                              (wval[1:0] == MTVEC_VECTORED) ? 2'b01 : 2'b00};
        CSR_MEPC:   if (!trap) mepc_d   = wval & ~XLEN'(3);
        CSR_MCAUSE: if (!trap) mcause_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mtie_q        <= 1'b0;
      meie_q        <= 1'b0;
      mtvec_q       <= XLEN'(MTVEC_RESET);
      mepc_q        <= '0;
      mcause_q      <= '0;
    end else begin
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      mtie_q        <= mtie_d;
      meie_q        <= meie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
    end
  end

  csr_cycle_counter #(.CYCLE_W(CYCLE_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (wr_lo),
    .wr_hi (wr_hi),
    .wdata (wval[CYCLE_W/2-1:0]),
    .count (cycle_cnt)
  );

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vec  = (mtvec_q[1:0] == MTVEC_VECTORED && mcause_q[XLEN-1]) ?
                     tvec_base + XLEN'({mcause_q[4:0], 2'b00}) : tvec_base;
  assign epc       = mepc_q;
  assign irq_req   = mstatus_mie_q & ((mtie_q & irq_timer) | (meie_q & irq_ext));

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of single-cycle CSR accesses followed by
// hand-written trap, mret, priority, cycle-counter and reset sequences.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_rd;
  logic [31:0] wdata, pc, cause;
  logic        trap, mret, irq_timer, irq_ext;
  logic [31:0] rdata, epc, trap_vec;
  logic        illegal, irq_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .CYCLE_W(64), .MTVEC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_rd(csr_rd), .wdata(wdata), .pc(pc), .trap(trap), .cause(cause),
    .mret(mret), .irq_timer(irq_timer), .irq_ext(irq_ext), .rdata(rdata),
    .illegal(illegal), .epc(epc), .trap_vec(trap_vec), .irq_req(irq_req)
  );

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic        rd;
    logic [31:0] wd;
    logic        tmr;
    logic        ext;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic [11:0] a, logic [1:0] o, logic r, logic [31:0] w,
                              logic t, logic e, logic [31:0] xr, logic xi, logic xq);
    vec_t v;
    v.addr = a; v.op = o; v.rd = r; v.wd = w; v.tmr = t; v.ext = e;
    v.exp_rdata = xr; v.exp_ill = xi; v.exp_irq = xq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] o, input logic r,
                       input logic [31:0] w);
    csr_addr = a; csr_op = o; csr_rd = r; wdata = w;
  endtask

  task automatic idle();
    drive(12'h000, 2'b00, 1'b0, 32'h0);
    trap = 1'b0; mret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(a, 2'b00, 1'b1, 32'h0);
    @(negedge clk);
    check(name, rdata, exp);
    tick();
  endtask

  initial begin
    vecs[0]  = mk(12'hB00, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[1]  = mk(12'hB80, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[2]  = mk(12'hB00, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0002, 0, 0);
    vecs[3]  = mk(12'h300, 2'b00, 1, 32'h0, 0, 0, 32'h0000_1800, 0, 0);
    vecs[4]  = mk(12'h304, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[5]  = mk(12'h305, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[6]  = mk(12'h341, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[7]  = mk(12'h342, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[8]  = mk(12'h344, 2'b00, 1, 32'h0, 1, 1, 32'h0000_0880, 0, 0);
    vecs[9]  = mk(12'h7C0, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0000, 1, 0);
    vecs[10] = mk(12'h7C0, 2'b00, 0, 32'h0, 0, 0, 32'h0000_0000, 0, 0);
    vecs[11] = mk(12'h344, 2'b01, 0, 32'h0, 0, 0, 32'h0000_0000, 1, 0);
    vecs[12] = mk(12'h304, 2'b01, 1, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 0, 0);
    vecs[13] = mk(12'h304, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0880, 0, 0);
    vecs[14] = mk(12'h300, 2'b10, 1, 32'h8, 0, 0, 32'h0000_1800, 0, 0);
    vecs[15] = mk(12'h300, 2'b00, 1, 32'h0, 0, 0, 32'h0000_1808, 0, 0);
    vecs[16] = mk(12'h300, 2'b11, 1, 32'h8, 0, 0, 32'h0000_1808, 0, 0);
    vecs[17] = mk(12'h300, 2'b00, 1, 32'h0, 0, 0, 32'h0000_1800, 0, 0);
    vecs[18] = mk(12'h300, 2'b10, 1, 32'h8, 0, 0, 32'h0000_1800, 0, 0);
    vecs[19] = mk(12'h300, 2'b00, 1, 32'h0, 1, 0, 32'h0000_1808, 0, 1);
    vecs[20] = mk(12'h305, 2'b01, 1, 32'h203, 0, 0, 32'h0000_0000, 0, 0);
    vecs[21] = mk(12'h305, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0200, 0, 0);
    vecs[22] = mk(12'h341, 2'b01, 1, 32'h103, 0, 0, 32'h0000_0000, 0, 0);
    vecs[23] = mk(12'h341, 2'b00, 1, 32'h0, 0, 0, 32'h0000_0100, 0, 0);
    vecs[24] = mk(12'h304, 2'b00, 1, 32'h0, 0, 1, 32'h0000_0880, 0, 1);
    vecs[25] = mk(12'h304, 2'b11, 1, 32'h80, 1, 0, 32'h0000_0880, 0, 1);
    vecs[26] = mk(12'h304, 2'b00, 1, 32'h0, 1, 0, 32'h0000_0800, 0, 0);
    vecs[27] = mk(12'h304, 2'b01, 1, 32'h80, 0, 0, 32'h0000_0800, 0, 0);
    vecs[28] = mk(12'h342, 2'b01, 0, 32'h8000_0003, 0, 0, 32'h0000_0000, 0, 0);
    vecs[29] = mk(12'h342, 2'b00, 1, 32'h0, 0, 0, 32'h8000_0003, 0, 0);

    rst = 1'b0; pc = '0; cause = '0; irq_timer = 1'b0; irq_ext = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_epc", epc, 32'h0);
    check("reset_trap_vec", trap_vec, 32'h0);
    check("reset_irq_req", {31'b0, irq_req}, 32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].addr, vecs[i].op, vecs[i].rd, vecs[i].wd);
      irq_timer = vecs[i].tmr; irq_ext = vecs[i].ext;
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].exp_ill});
      check($sformatf("vec%0d_irq_req", i), {31'b0, irq_req}, {31'b0, vecs[i].exp_irq});
      tick();
    end

    // Interrupt trap, vectored target, then mret.
    idle(); irq_timer = 1'b1; irq_ext = 1'b0;
    @(negedge clk);
    check("pre_trap_vec_direct", trap_vec, 32'h200);
    check("pre_trap_irq_req", {31'b0, irq_req}, 32'h1);
    tick();
    trap = 1'b1; pc = 32'h100; cause = 32'h8000_0007;
    tick();
    trap = 1'b0;
    drive(12'h300, 2'b00, 1'b1, 32'h0);
    @(negedge clk);
    check("trap_mstatus", rdata, 32'h1880);
    check("trap_epc", epc, 32'h100);
    check("trap_irq_req", {31'b0, irq_req}, 32'h0);
    tick();
    drive(12'h305, 2'b01, 1'b0, 32'h201);
    tick();
    idle();
    @(negedge clk);
    check("trap_vec_vectored", trap_vec, 32'h21C);
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    drive(12'h300, 2'b00, 1'b1, 32'h0);
    @(negedge clk);
    check("mret_mstatus", rdata, 32'h1888);
    check("mret_irq_req", {31'b0, irq_req}, 32'h1);
    tick();

    // Priority: trap over mret over the mstatus write.
    trap = 1'b1; mret = 1'b1; pc = 32'h240; cause = 32'h2;
    drive(12'h300, 2'b01, 1'b0, 32'h0);
    tick();
    idle();
    drive(12'h300, 2'b00, 1'b1, 32'h0);
    @(negedge clk);
    check("prio_trap_mstatus", rdata, 32'h1880);
    check("prio_trap_epc", epc, 32'h240);
    check("prio_trap_vec_exc", trap_vec, 32'h200);
    tick();
    read_check("prio_trap_mcause", 12'h342, 32'h2);
    mret = 1'b1;
    drive(12'h300, 2'b01, 1'b0, 32'h0);
    tick();
    mret = 1'b0;
    read_check("prio_mret_mstatus", 12'h300, 32'h1888);

    // Cycle counter: wrap through all-ones, then no carry out of a written half.
    drive(12'hB80, 2'b01, 1'b0, 32'hFFFF_FFFF);
    tick();
    drive(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFF);
    tick();
    read_check("cyc_hi_ones", 12'hB80, 32'hFFFF_FFFF);
    read_check("cyc_lo_wrap", 12'hB00, 32'h0);
    read_check("cyc_hi_wrap", 12'hB80, 32'h0);
    drive(12'hB80, 2'b01, 1'b0, 32'h5);
    tick();
    drive(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFF);
    tick();
    read_check("cyc_hi_nocarry", 12'hB80, 32'h5);
    read_check("cyc_hi_carry", 12'hB80, 32'h6);

    // Reset from a non-idle state.
    idle(); irq_timer = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(12'h300, 2'b00, 1'b1, 32'h0);
    @(negedge clk);
    check("rst2_mstatus", rdata, 32'h1800);
    check("rst2_epc", epc, 32'h0);
    check("rst2_trap_vec", trap_vec, 32'h0);
    check("rst2_irq_req", {31'b0, irq_req}, 32'h0);
    tick();
    read_check("rst2_mcycle", 12'hB00, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
